// File: rtl/temporizador_semaforo.sv
// Environment companion of the traffic-light controller: debounces the vehicle
// sensor into CAR, times the red phase into TIMEOUT and flags lamp protocol errors.
//
// prev lamp state | meaning
// LAMP_G          | last legal pattern seen was green (also the reset state)
// LAMP_Y          | last legal pattern seen was yellow
// LAMP_R          | last legal pattern seen was red
module temporizador_semaforo #(
    parameter int T_VERMELHO  = 8,
    parameter int DEB         = 3,
    parameter int T_VERDE_MIN = 4
) (
    input  logic clk,
    input  logic res,
    input  logic SENSOR,
    input  logic VERDE,
    input  logic AMARELO,
    input  logic VERMELHO,
    output logic CAR,
    output logic TIMEOUT,
    output logic ERRO
);

    localparam int DW  = (DEB > 1) ? $clog2(DEB) : 1;
    localparam int VGW = $clog2(T_VERDE_MIN + 1);
    localparam int VMW = $clog2(T_VERMELHO + 1);

    localparam logic [DW-1:0]  DEB_LAST = DW'(DEB - 1);
    localparam logic [VGW-1:0] VG_MAX   = VGW'(T_VERDE_MIN);
    localparam logic [VMW-1:0] VM_MAX   = VMW'(T_VERMELHO);
    localparam logic [VMW-1:0] VM_TO    = VMW'(T_VERMELHO - 2);

    typedef enum logic [1:0] {
        LAMP_G = 2'd0,
        LAMP_Y = 2'd1,
        LAMP_R = 2'd2
    } lamp_t;

    logic           s1, s2, filt;
    logic [DW-1:0]  deb_cnt;
    logic [VGW-1:0] verde_cnt;
    logic [VMW-1:0] verm_cnt;
    lamp_t          prev, cur;
    logic           legal, is_g, is_r, trans_ok;

    always_comb begin
        cur   = prev;
        legal = 1'b1;
        case ({VERDE, AMARELO, VERMELHO})
            3'b100:  cur = LAMP_G;
            3'b010:  cur = LAMP_Y;
            3'b001:  cur = LAMP_R;
            default: legal = 1'b0;
        endcase
    end

    assign is_g = legal && (cur == LAMP_G);
    assign is_r = legal && (cur == LAMP_R);

    // Y->Y is deliberately absent: yellow must last exactly one cycle.
    assign trans_ok = legal &&
        (((prev == LAMP_G) && ((cur == LAMP_G) || (cur == LAMP_Y))) ||
         ((prev == LAMP_Y) && (cur == LAMP_R)) ||
         ((prev == LAMP_R) && ((cur == LAMP_R) || (cur == LAMP_G))));

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            filt    <= 1'b0;
            deb_cnt <= '0;
        end else begin
            s1 <= SENSOR;
            s2 <= s1;
            if (s2 != filt) begin
                if (deb_cnt == DEB_LAST) begin
                    filt    <= ~filt;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + DW'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            prev      <= LAMP_G;
            verde_cnt <= '0;
            verm_cnt  <= '0;
            CAR       <= 1'b0;
            TIMEOUT   <= 1'b0;
            ERRO      <= 1'b0;
        end else begin
            if (legal) begin
                prev <= cur;
            end

            if (is_g) begin
                if (verde_cnt != VG_MAX) verde_cnt <= verde_cnt + VGW'(1);
            end else begin
                verde_cnt <= '0;
            end

            if (is_r) begin
                if (verm_cnt != VM_MAX) verm_cnt <= verm_cnt + VMW'(1);
            end else begin
                verm_cnt <= '0;
            end

            CAR     <= is_g && filt && (verde_cnt >= VG_MAX);
            // Fires one edge early so the controller leaves red after exactly T_VERMELHO cycles.
            TIMEOUT <= is_r && (verm_cnt == VM_TO);

            if (!trans_ok || (is_r && (verm_cnt == VM_MAX))) begin
                ERRO <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_temporizador_semaforo.sv
// Bench for temporizador_semaforo: directed protocol scenarios plus randomized
// closed-loop traffic, all checked against a history-based reference model.
module tb_temporizador_semaforo;

    localparam int TV = 8;
    localparam int DB = 3;
    localparam int TG = 4;
    localparam logic [2:0] PG = 3'b100;
    localparam logic [2:0] PY = 3'b010;
    localparam logic [2:0] PR = 3'b001;

    logic clk = 1'b0;
    logic res = 1'b0;
    logic SENSOR = 1'b0;
    logic VERDE = 1'b1;
    logic AMARELO = 1'b0;
    logic VERMELHO = 1'b0;
    logic CAR, TIMEOUT, ERRO;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_no = 0;

    bit         sen_h[$];
    logic [2:0] lam_h[$];
    bit         m_filt;
    int         m_last_toggle;
    bit         m_err;

    always #5 clk = ~clk;

    temporizador_semaforo #(
        .T_VERMELHO (TV),
        .DEB        (DB),
        .T_VERDE_MIN(TG)
    ) dut (
        .clk     (clk),
        .res     (res),
        .SENSOR  (SENSOR),
        .VERDE   (VERDE),
        .AMARELO (AMARELO),
        .VERMELHO(VERMELHO),
        .CAR     (CAR),
        .TIMEOUT (TIMEOUT),
        .ERRO    (ERRO)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s (edge %0d): observed %b expected %b", tag, edge_no, obs, exp);
        end
    endtask

    // Consecutive edges immediately before the current one that showed pattern p.
    function automatic int run_before(input logic [2:0] p);
        int r;
        r = 0;
        for (int i = lam_h.size() - 1; i >= 0; i--) begin
            if (lam_h[i] !== p) break;
            r++;
        end
        return r;
    endfunction

    function automatic logic [2:0] last_legal();
        for (int i = lam_h.size() - 1; i >= 0; i--) begin
            if (lam_h[i] === PG || lam_h[i] === PY || lam_h[i] === PR) return lam_h[i];
        end
        return PG;
    endfunction

    function automatic bit allowed(input logic [2:0] p, input logic [2:0] c);
        return (p == PG && (c == PG || c == PY)) || (p == PY && c == PR) ||
               (p == PR && (c == PR || c == PG));
    endfunction

    // Synchronized sensor as seen at edge n: the raw value present at edge n-2.
    function automatic bit s2_at(input int n);
        return (n >= 3) ? sen_h[n-3] : 1'b0;
    endfunction

    task automatic model_reset();
        sen_h.delete();
        lam_h.delete();
        m_filt = 1'b0;
        m_last_toggle = 0;
        m_err = 1'b0;
        edge_no = 0;
    endtask

    task automatic model_edge(input bit sen, input logic [2:0] lam,
                              output bit e_car, output bit e_to, output bit e_err);
        int n;
        int g_run;
        int r_run;
        bit flip;
        logic [2:0] pv;
        n     = lam_h.size() + 1;
        g_run = run_before(PG);
        r_run = run_before(PR);
        pv    = last_legal();
        e_car = (lam == PG) && m_filt && (g_run >= TG);
        e_to  = (lam == PR) && (r_run == TV - 2);
        if (!(lam == PG || lam == PY || lam == PR) || !allowed(pv, lam) ||
            (lam == PR && r_run >= TV))
            m_err = 1'b1;
        e_err = m_err;
        // Filter flips once DB consecutive synchronized samples since the last flip disagree with it.
        flip = (n - m_last_toggle >= DB);
        for (int k = n - DB + 1; k <= n; k++) begin
            if (s2_at(k) == m_filt) flip = 1'b0;
        end
        if (flip) begin
            m_filt = ~m_filt;
            m_last_toggle = n;
        end
        sen_h.push_back(sen);
        lam_h.push_back(lam);
    endtask

    task automatic tick(input bit sen, input logic [2:0] lam);
        bit ec, et, ee;
        SENSOR = sen;
        {VERDE, AMARELO, VERMELHO} = lam;
        @(posedge clk);
        #1;
        edge_no++;
        model_edge(sen, lam, ec, et, ee);
        check("car", CAR, ec);
        check("timeout", TIMEOUT, et);
        check("erro", ERRO, ee);
    endtask

    task automatic do_reset();
        {VERDE, AMARELO, VERMELHO} = PG;
        SENSOR = 1'b0;
        res = 1'b0;
        #1;
        model_reset();
        check("rst_car", CAR, 1'b0);
        check("rst_timeout", TIMEOUT, 1'b0);
        check("rst_erro", ERRO, 1'b0);
        @(posedge clk);
        #1;
        res = 1'b1;
    endtask

    function automatic logic [2:0] ctrl_next(input logic [2:0] l, input bit car, input bit to);
        case (l)
            PG:      return car ? PY : PG;
            PY:      return PR;
            PR:      return to ? PG : PR;
            default: return PG;
        endcase
    endfunction

    initial begin
        logic [2:0] c_lam, lam;
        bit o_car, o_to, sen;
        int hold, to_cnt;

        // Closed loop with a behavioural controller, defaults.
        do_reset();
        c_lam = PG;
        for (int e = 1; e <= 40; e++) begin
            o_car = CAR;
            o_to  = TIMEOUT;
            tick(e >= 10, c_lam);
            if (e == 14) check("cl_car_e14", CAR, 1'b0);
            if (e == 15) check("cl_car_e15", CAR, 1'b1);
            if (e == 23) check("cl_to_e23", TIMEOUT, 1'b0);
            if (e == 24) check("cl_to_e24", TIMEOUT, 1'b1);
            if (e == 25) check("cl_to_e25", TIMEOUT, 1'b0);
            c_lam = ctrl_next(c_lam, o_car, o_to);
            if (e == 16) check("cl_yellow_e16", c_lam == PY, 1'b1);
            if (e == 17) check("cl_red_e17", c_lam == PR, 1'b1);
            if (e == 25) check("cl_green_e25", c_lam == PG, 1'b1);
        end
        check("cl_erro_end", ERRO, 1'b0);

        // Two-cycle glitch during green.
        do_reset();
        for (int k = 0; k < 17; k++) begin
            tick(k >= 5 && k < 7, PG);
            check("glitch_car", CAR, 1'b0);
        end

        // Minimum green after a red phase with the sensor held high.
        do_reset();
        tick(1, PG);
        tick(1, PG);
        tick(1, PY);
        for (int k = 0; k < TV; k++) tick(1, PR);
        for (int k = 1; k <= 6; k++) begin
            tick(1, PG);
            check("mingreen_car", CAR, k >= 5);
        end

        // Illegal pattern is sticky until reset.
        do_reset();
        for (int k = 0; k < 3; k++) tick(0, PG);
        tick(0, 3'b101);
        check("illegal_erro", ERRO, 1'b1);
        for (int k = 0; k < 3; k++) tick(0, PG);
        check("illegal_sticky", ERRO, 1'b1);
        res = 1'b0;
        #1;
        check("illegal_async_clr", ERRO, 1'b0);

        // Red overrun: TIMEOUT ignored for nine red edges.
        do_reset();
        tick(0, PG);
        tick(0, PG);
        tick(0, PY);
        to_cnt = 0;
        for (int k = 1; k <= 9; k++) begin
            tick(0, PR);
            to_cnt += int'(TIMEOUT);
            check("overrun_erro", ERRO, k == 9);
        end
        check("overrun_single_to", to_cnt == 1, 1'b1);

        // G->R and Y->Y.
        do_reset();
        tick(0, PG);
        tick(0, PR);
        check("g_to_r_erro", ERRO, 1'b1);
        do_reset();
        tick(0, PG);
        tick(0, PY);
        check("y_first_erro", ERRO, 1'b0);
        tick(0, PY);
        check("y_to_y_erro", ERRO, 1'b1);

        // Reset in the middle of a red phase.
        do_reset();
        tick(1, PG);
        tick(1, PG);
        tick(1, PY);
        for (int k = 0; k < 4; k++) tick(1, PR);
        res = 1'b0;
        #1;
        check("midred_car", CAR, 1'b0);
        check("midred_timeout", TIMEOUT, 1'b0);
        check("midred_erro", ERRO, 1'b0);
        do_reset();
        to_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick(0, PG);
            to_cnt += int'(TIMEOUT);
        end
        check("midred_no_to", to_cnt == 0, 1'b1);
        tick(0, PY);
        for (int k = 1; k <= TV; k++) begin
            tick(0, PR);
            check("midred_red_to", TIMEOUT, k == TV - 1);
        end
        tick(0, PG);
        check("midred_erro_end", ERRO, 1'b0);

        // Randomized closed loop, well-behaved controller.
        do_reset();
        c_lam = PG;
        sen = 1'b0;
        hold = 0;
        for (int e = 0; e < 400; e++) begin
            if (hold == 0) begin
                sen  = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 8);
            end
            hold--;
            o_car = CAR;
            o_to  = TIMEOUT;
            tick(sen, c_lam);
            c_lam = ctrl_next(c_lam, o_car, o_to);
        end
        check("rand_clean_erro", ERRO, 1'b0);

        // Randomized closed loop with corrupted lamps and occasional resets.
        do_reset();
        c_lam = PG;
        hold = 0;
        for (int e = 0; e < 500; e++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
                c_lam = PG;
            end
            if (hold == 0) begin
                sen  = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 8);
            end
            hold--;
            lam = ($urandom_range(0, 99) < 3) ? 3'($urandom_range(0, 7)) : c_lam;
            o_car = CAR;
            o_to  = TIMEOUT;
            tick(sen, lam);
            c_lam = ctrl_next(c_lam, o_car, o_to);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
